// File: rtl/serv_ram_arbiter_pkg.sv
// Shared types for the SERV RAM arbiter: FSM states, grant codes and byte-lane helpers.
package serv_ram_arbiter_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_HOST,
    GNT_DBUS,
    GNT_IBUS
  } gnt_e;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_B0   = 4'b0001;

  function automatic logic [3:0] lane_onehot(input logic [1:0] byte_off);
    return LANE_B0 << byte_off;
  endfunction

endpackage

// File: rtl/serv_ram_arbiter_host_latch.sv
// Pending-write register for the byte-wide host load path; a new strobe always
// replaces whatever is pending, and busy drops once the arbiter takes the entry.
module serv_ram_host_latch #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W+1:0] i_addr,
  input  logic [7:0]        i_data,
  input  logic              i_clr,
  output logic              o_busy,
  output logic [ADDR_W+1:0] o_addr,
  output logic [7:0]        o_data
);

  logic              busy_d, busy_q;
  logic [ADDR_W+1:0] addr_d, addr_q;
  logic [7:0]        data_d, data_q;

  // A strobe on the same edge the old entry is consumed keeps busy set for the new one.
  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    data_d = data_q;
    if (i_we) begin
      busy_d = 1'b1;
      addr_d = i_addr;
      data_d = i_data;
    end else if (i_clr) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign o_busy = busy_q;
  assign o_addr = addr_q;
  assign o_data = data_q;

endmodule

// File: rtl/serv_ram_arbiter.sv
// Arbitrates host > dbus > ibus onto the single-port RAM32 macro, one access per two cycles.
// Optional write protection of the low words is enabled with SERV_RAM_WP_EN.
module serv_ram_arbiter
  import serv_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int WP_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ibus_cyc,
  input  logic [31:0]       i_ibus_adr,
  output logic [31:0]       o_ibus_rdt,
  output logic              o_ibus_ack,
  input  logic              i_dbus_cyc,
  input  logic [31:0]       i_dbus_adr,
  input  logic              i_dbus_we,
  input  logic [31:0]       i_dbus_dat,
  input  logic [3:0]        i_dbus_sel,
  output logic [31:0]       o_dbus_rdt,
  output logic              o_dbus_ack,
  input  logic              i_host_we,
  input  logic [ADDR_W+1:0] i_host_addr,
  input  logic [7:0]        i_host_data,
  output logic              o_host_busy,
  output logic              o_ram_en,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic [3:0]        o_ram_we,
  output logic [31:0]       o_ram_di,
  input  logic [31:0]       i_ram_do,
  output logic              o_wp_hit
);

  logic              host_busy;
  logic [ADDR_W+1:0] host_addr;
  logic [7:0]        host_data;
  gnt_e              gnt;
  logic              dbus_in_range, ibus_in_range;
  logic [ADDR_W-1:0] dbus_word;
  logic              ram_en, oor;
  logic [ADDR_W-1:0] ram_a;
  logic [3:0]        ram_we;
  logic [31:0]       ram_di, resp_data;
  logic              unused_adr_lsbs;

  state_e      state_d, state_q;
  gnt_e        gnt_d, gnt_q;
  logic        oor_d, oor_q;
  logic        ibus_ack_d, ibus_ack_q, dbus_ack_d, dbus_ack_q;
  logic        ibus_ack_prev_d, ibus_ack_prev_q, dbus_ack_prev_d, dbus_ack_prev_q;
  logic [31:0] ibus_rdt_d, ibus_rdt_q, dbus_rdt_d, dbus_rdt_q;

`ifdef SERV_RAM_WP_EN
  localparam logic [ADDR_W:0] WP_LIMIT = (ADDR_W+1)'(WP_WORDS);
  logic dbus_low_word, wp_block;
  logic wp_hit_d, wp_hit_q;
  assign dbus_low_word = ({1'b0, dbus_word} < WP_LIMIT);
`endif

  serv_ram_host_latch #(.ADDR_W(ADDR_W)) u_host_latch (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (i_host_we),
    .i_addr (i_host_addr),
    .i_data (i_host_data),
    .i_clr  (gnt == GNT_HOST),
    .o_busy (host_busy),
    .o_addr (host_addr),
    .o_data (host_data)
  );

  assign dbus_in_range   = (i_dbus_adr[31:ADDR_W+2] == '0);
  assign ibus_in_range   = (i_ibus_adr[31:ADDR_W+2] == '0);
  assign dbus_word       = i_dbus_adr[ADDR_W+1:2];
  assign unused_adr_lsbs = ^{i_dbus_adr[1:0], i_ibus_adr[1:0]};

  // A master whose ack was high last cycle is still holding cyc from that access.
  always_comb begin
    gnt = GNT_NONE;
    if (state_q == ST_IDLE) begin
      if (host_busy)                               gnt = GNT_HOST;
      else if (i_dbus_cyc && !dbus_ack_prev_q)     gnt = GNT_DBUS;
      else if (i_ibus_cyc && !ibus_ack_prev_q)     gnt = GNT_IBUS;
    end
  end

  always_comb begin
    ram_en = 1'b0;
    ram_a  = '0;
    ram_we = LANE_NONE;
    ram_di = '0;
    oor    = 1'b0;
`ifdef SERV_RAM_WP_EN
    wp_block = 1'b0;
`endif
    case (gnt)
      GNT_HOST: begin
        ram_en = 1'b1;
        ram_a  = host_addr[ADDR_W+1:2];
        ram_we = lane_onehot(host_addr[1:0]);
        ram_di = {4{host_data}};
      end
      GNT_DBUS: begin
        ram_en = dbus_in_range;
        oor    = !dbus_in_range;
        ram_a  = dbus_word;
        ram_di = i_dbus_dat;
        if (i_dbus_we && dbus_in_range) ram_we = i_dbus_sel;
`ifdef SERV_RAM_WP_EN
        if (i_dbus_we && dbus_in_range && dbus_low_word) begin
          ram_we   = LANE_NONE;
          wp_block = 1'b1;
        end
`endif
      end
      GNT_IBUS: begin
        ram_en = ibus_in_range;
        oor    = !ibus_in_range;
        ram_a  = i_ibus_adr[ADDR_W+1:2];
      end
      default: ;
    endcase
  end

  assign o_ram_en = rst_n & ram_en;
  assign o_ram_we = rst_n ? ram_we : LANE_NONE;
  assign o_ram_a  = ram_a;
  assign o_ram_di = ram_di;

  assign resp_data = oor_q ? 32'h0 : i_ram_do;

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    oor_d           = oor_q;
    ibus_ack_d      = 1'b0;
    dbus_ack_d      = 1'b0;
    ibus_ack_prev_d = ibus_ack_q;
    dbus_ack_prev_d = dbus_ack_q;
    ibus_rdt_d      = ibus_rdt_q;
    dbus_rdt_d      = dbus_rdt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != GNT_NONE) begin
          state_d    = ST_RESP;
          gnt_d      = gnt;
          oor_d      = oor;
          ibus_ack_d = (gnt == GNT_IBUS);
          dbus_ack_d = (gnt == GNT_DBUS);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
        if (gnt_q == GNT_IBUS) ibus_rdt_d = resp_data;
        if (gnt_q == GNT_DBUS) dbus_rdt_d = resp_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      gnt_q           <= GNT_NONE;
      oor_q           <= 1'b0;
      ibus_ack_q      <= 1'b0;
      dbus_ack_q      <= 1'b0;
      ibus_ack_prev_q <= 1'b0;
      dbus_ack_prev_q <= 1'b0;
      ibus_rdt_q      <= '0;
      dbus_rdt_q      <= '0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      oor_q           <= oor_d;
      ibus_ack_q      <= ibus_ack_d;
      dbus_ack_q      <= dbus_ack_d;
      ibus_ack_prev_q <= ibus_ack_prev_d;
      dbus_ack_prev_q <= dbus_ack_prev_d;
      ibus_rdt_q      <= ibus_rdt_d;
      dbus_rdt_q      <= dbus_rdt_d;
    end
  end

  // The macro's Do is already registered, so it is passed through during the ack cycle and held afterwards.
  assign o_ibus_rdt = (state_q == ST_RESP && gnt_q == GNT_IBUS) ? resp_data : ibus_rdt_q;
  assign o_dbus_rdt = (state_q == ST_RESP && gnt_q == GNT_DBUS) ? resp_data : dbus_rdt_q;
  assign o_ibus_ack = ibus_ack_q & rst_n;
  assign o_dbus_ack = dbus_ack_q & rst_n;
  assign o_host_busy = host_busy;

`ifdef SERV_RAM_WP_EN
  assign wp_hit_d = wp_hit_q | wp_block;

  always_ff @(posedge clk) begin
    if (!rst_n) wp_hit_q <= 1'b0;
    else        wp_hit_q <= wp_hit_d;
  end

  assign o_wp_hit = wp_hit_q;
`else
  logic unused_wp;
  assign unused_wp = (WP_WORDS < 0);
  assign o_wp_hit  = 1'b0;
`endif

endmodule

// File: tb/tb_serv_ram_arbiter.sv
// Directed bench for serv_ram_arbiter with a behavioural RAM32 model and an ack scoreboard.
module tb_serv_ram_arbiter;

  localparam int ADDR_W = 5;
`ifdef SERV_RAM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ibus_cyc, ibus_ack, dbus_cyc, dbus_we, dbus_ack;
  logic [31:0]       ibus_adr, ibus_rdt, dbus_adr, dbus_dat, dbus_rdt;
  logic [3:0]        dbus_sel, ram_we;
  logic              host_we, host_busy, ram_en, wp_hit;
  logic [ADDR_W+1:0] host_addr;
  logic [7:0]        host_data;
  logic [ADDR_W-1:0] ram_a;
  logic [31:0]       ram_di, ram_do;

  logic [31:0] mem [32] = '{default: 32'h0};
  int en_cycles = 0;
  int n_asserts = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    bit          is_dbus;
    logic [31:0] rdt;
    bit          chk_rdt;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  serv_ram_arbiter #(.ADDR_W(ADDR_W), .WP_WORDS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ibus_cyc  (ibus_cyc),
    .i_ibus_adr  (ibus_adr),
    .o_ibus_rdt  (ibus_rdt),
    .o_ibus_ack  (ibus_ack),
    .i_dbus_cyc  (dbus_cyc),
    .i_dbus_adr  (dbus_adr),
    .i_dbus_we   (dbus_we),
    .i_dbus_dat  (dbus_dat),
    .i_dbus_sel  (dbus_sel),
    .o_dbus_rdt  (dbus_rdt),
    .o_dbus_ack  (dbus_ack),
    .i_host_we   (host_we),
    .i_host_addr (host_addr),
    .i_host_data (host_data),
    .o_host_busy (host_busy),
    .o_ram_en    (ram_en),
    .o_ram_a     (ram_a),
    .o_ram_we    (ram_we),
    .o_ram_di    (ram_di),
    .i_ram_do    (ram_do),
    .o_wp_hit    (wp_hit)
  );

  // RAM32 model: byte-lane writes, Do shows the pre-write word the cycle after an enabled edge.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      ram_do <= mem[ram_a];
      en_cycles++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit is_dbus, input logic [31:0] adr,
                               input bit we, input logic [31:0] dat, input logic [3:0] sel,
                               input logic [31:0] exp_rdt, input bit chk, input int lat);
    exp_t e;
    e.tag = tag; e.is_dbus = is_dbus; e.rdt = exp_rdt; e.chk_rdt = chk; e.lat = lat;
    sb.push_back(e);
    if (is_dbus) begin
      dbus_cyc = 1'b1; dbus_adr = adr; dbus_we = we; dbus_dat = dat; dbus_sel = sel;
    end else begin
      ibus_cyc = 1'b1; ibus_adr = adr;
    end
  endtask

  // Pops the oldest expectation, waits a bounded number of cycles for its ack, then
  // holds cyc one more edge to confirm the same request is not served twice.
  task automatic waitAck(input int start);
    exp_t e;
    int   n;
    bit   got;
    e = sb.pop_front();
    n = start;
    got = 1'b0;
    while (!got && n < 10) begin
      @(posedge clk); @(negedge clk);
      n++;
      got = e.is_dbus ? dbus_ack : ibus_ack;
    end
    checkOutput({e.tag, " ack latency"}, 32'(n), 32'(e.lat));
    if (got && e.chk_rdt)
      checkOutput({e.tag, " rdt"}, e.is_dbus ? dbus_rdt : ibus_rdt, e.rdt);
    @(posedge clk); @(negedge clk);
    checkOutput({e.tag, " ack single pulse"}, 32'(e.is_dbus ? dbus_ack : ibus_ack), 32'd0);
    @(posedge clk); #1;
    dbus_cyc = 1'b0; ibus_cyc = 1'b0;
    @(negedge clk);
    checkOutput({e.tag, " held cyc not reserved"}, 32'(e.is_dbus ? dbus_ack : ibus_ack), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic hostWrite(input logic [ADDR_W+1:0] addr, input logic [7:0] data);
    host_we = 1'b1; host_addr = addr; host_data = data;
    @(posedge clk); #1;
    host_we = 1'b0;
    @(negedge clk);
    checkOutput("host busy set", 32'(host_busy), 32'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("host busy cleared", 32'(host_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic hostWord(input int byte_addr, input logic [31:0] word);
    for (int i = 0; i < 4; i++)
      hostWrite((ADDR_W+2)'(byte_addr + i), word[8*i +: 8]);
  endtask

  task automatic dbusRead(input string tag, input logic [31:0] adr, input logic [31:0] exp_rdt);
    applyStimulus(tag, 1'b1, adr, 1'b0, 32'h0, 4'h0, exp_rdt, 1'b1, 1);
    waitAck(0);
  endtask

  initial begin
    int en_snap;
    rst_n = 1'b0;
    ibus_cyc = 1'b0; ibus_adr = '0;
    dbus_cyc = 1'b1; dbus_adr = '0; dbus_we = 1'b1; dbus_dat = '1; dbus_sel = 4'hF;
    host_we = 1'b0; host_addr = '0; host_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ram_en", 32'(ram_en), 32'd0);
    checkOutput("reset ram_we", 32'(ram_we), 32'd0);
    checkOutput("reset ibus_ack", 32'(ibus_ack), 32'd0);
    checkOutput("reset dbus_ack", 32'(dbus_ack), 32'd0);
    checkOutput("reset host_busy", 32'(host_busy), 32'd0);
    checkOutput("reset wp_hit", 32'(wp_hit), 32'd0);
    checkOutput("reset ibus_rdt", ibus_rdt, 32'h0);
    checkOutput("reset dbus_rdt", dbus_rdt, 32'h0);
    @(posedge clk); #1;
    dbus_cyc = 1'b0; dbus_we = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] ibus read after host preload");
    hostWord(12, 32'hDEADBEEF);
    applyStimulus("ibus read 0x0C", 1'b0, 32'h0000_000C, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 1);
    waitAck(0);
    checkOutput("ibus rdt held", ibus_rdt, 32'hDEADBEEF);

    $display("[TB] dbus byte-lane write");
    hostWord(16, 32'h11223344);
    dbusRead("dbus read 0x10", 32'h0000_0010, 32'h11223344);
    applyStimulus("dbus write sel 0100", 1'b1, 32'h0000_0010, 1'b1, 32'h00AA0000, 4'b0100, 32'h0, 1'b0, 1);
    waitAck(0);
    dbusRead("dbus readback 0x10", 32'h0000_0010, WP ? 32'h11223344 : 32'h11AA3344);

    $display("[TB] host and dbus contention");
    host_we = 1'b1; host_addr = 7'd8; host_data = 8'h5A;
    @(posedge clk); #1;
    host_we = 1'b0;
    applyStimulus("contention dbus read", 1'b1, 32'h0000_0008, 1'b0, 32'h0, 4'h0, 32'h0000005A, 1'b1, 3);
    @(negedge clk);
    checkOutput("contention busy during host grant", 32'(host_busy), 32'd1);
    checkOutput("contention dbus waits", 32'(dbus_ack), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("contention busy cleared", 32'(host_busy), 32'd0);
    checkOutput("contention dbus still waiting", 32'(dbus_ack), 32'd0);
    waitAck(1);

    $display("[TB] host overwrite");
    host_we = 1'b1; host_addr = 7'd5; host_data = 8'h11;
    @(posedge clk); #1;
    host_data = 8'h22;
    @(posedge clk); #1;
    host_we = 1'b0;
    @(negedge clk);
    checkOutput("overwrite keeps busy", 32'(host_busy), 32'd1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    checkOutput("overwrite busy cleared", 32'(host_busy), 32'd0);
    @(posedge clk); #1;
    dbusRead("overwrite readback 0x04", 32'h0000_0004, 32'h00002200);

    $display("[TB] out of range accesses");
    en_snap = en_cycles;
    dbusRead("oor read 0x100", 32'h0000_0100, 32'h0);
    applyStimulus("oor write 0x100", 1'b1, 32'h0000_0100, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1);
    waitAck(0);
    checkOutput("oor ram_en never high", 32'(en_cycles), 32'(en_snap));
    dbusRead("oor word 0 untouched", 32'h0000_0000, 32'h0);

    $display("[TB] write protect region");
    applyStimulus("dbus write 0x04", 1'b1, 32'h0000_0004, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1);
    waitAck(0);
    dbusRead("wp readback 0x04", 32'h0000_0004, WP ? 32'h00002200 : 32'hCAFEF00D);
    checkOutput("wp_hit flag", 32'(wp_hit), 32'(WP));

    $display("[TB] reset during response");
    dbus_cyc = 1'b1; dbus_adr = 32'h0000_000C; dbus_we = 1'b0;
    host_we = 1'b1; host_addr = 7'd16; host_data = 8'h77;
    @(posedge clk); #1;
    host_we = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset in resp no ack", 32'(dbus_ack), 32'd0);
    checkOutput("host pending before reset edge", 32'(host_busy), 32'd1);
    @(posedge clk); #1;
    dbus_cyc = 1'b0;
    @(negedge clk);
    checkOutput("reset drops host pending", 32'(host_busy), 32'd0);
    checkOutput("reset no late ack", 32'(dbus_ack), 32'd0);
    checkOutput("reset clears wp_hit", 32'(wp_hit), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dbusRead("dropped host write", 32'h0000_0010, WP ? 32'h11223344 : 32'h11AA3344);
    applyStimulus("ibus read after reset", 1'b0, 32'h0000_000C, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 1);
    waitAck(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
